fifo_sync_prog: RTL and testbench

//  Parametrised single-clock FIFO, successor to the fixed 16x8 FIFO.

---
 rtl/fifo_sync_prog.sv | 164 ++++++++++++++++
 tb/tb_fifo_sync_prog.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: parametrised single-clock FIFO with runtime thresholds, flush and an optional
// first-word-fall-through read port.
//
// Parameters
//   FIFO_WIDTH  data width in bits
//   FIFO_DEPTH  number of entries (>= 2, any value, not only powers of two)
//   FWFT        0 = registered read data (1-cycle latency), 1 = head entry shown combinationally
//   CNT_W       width of count and thresholds (derived from FIFO_DEPTH, leave at default)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   flush        synchronous clear of contents (rst_n has priority)
//   data_in      write data
//   wr_en        write request
//   rd_en        read request (in FWFT mode: pop the visible head)
//   af_thresh    almost-full threshold  (almostfull  = count >= af_thresh)
//   ae_thresh    almost-empty threshold (almostempty = count <= ae_thresh)
//   data_out     read data
//   wr_ack       write accepted, one-cycle pulse after the write edge
//   overflow     write rejected because full, one-cycle pulse
//   underflow    read rejected because empty, one-cycle pulse
//   full/empty   occupancy flags
//   almostfull   threshold flag
//   almostempty  threshold flag
//   count        current occupancy
module fifo_sync_prog #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, overflow_q, underflow_q;

    logic wr_accept;
    logic rd_accept;
    logic advance;

    // Explicit wrap so that non-power-of-two depths index only valid entries.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Status flags come straight from the registered count and the live thresholds.
    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_thresh);
    assign almostempty = (count_q <= ae_thresh);
    assign count       = count_q;

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Acceptance uses the current flags, so a full FIFO cannot take a write even
    // when a read frees a slot on the same edge (and vice versa when empty).
    assign advance   = rst_n && !flush;
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (rd_accept) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_accept;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (advance && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is shown as soon as it is valid; an empty FIFO drives zero.
        always_comb begin
            data_out = '0;
            if (!empty) begin
                data_out = mem[rd_ptr_q];
            end
        end
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] data_out_q;

        // Registered read: updates only on an accepted read, holds through flush.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_out_q <= '0;
            end else if (!flush && rd_accept) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end

        assign data_out = data_out_q;
    end

endmodule

// File: tb/tb_fifo_sync_prog.sv
module tb_fifo_sync_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] data_in = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  af_thresh = 4'd6;
    logic [3:0]  ae_thresh = 4'd1;

    // Standard-mode instance, depth 8
    logic [15:0] s_dout;
    logic        s_ack, s_ovf, s_udf, s_full, s_empty, s_af, s_ae;
    logic [3:0]  s_count;
    // FWFT instance, depth 6
    logic [15:0] f_dout;
    logic        f_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae;
    logic [2:0]  f_count;

    always #5 clk = ~clk;

    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in), .wr_en(wr_en),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(s_dout),
        .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_udf), .full(s_full), .empty(s_empty),
        .almostfull(s_af), .almostempty(s_ae), .count(s_count)
    );

    fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in), .wr_en(wr_en),
        .rd_en(rd_en), .af_thresh(af_thresh[2:0]), .ae_thresh(ae_thresh[2:0]),
        .data_out(f_dout), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_udf),
        .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
        .count(f_count)
    );

    typedef struct {
        bit          fwft;
        int          count;
        bit          ack;
        bit          ovf;
        bit          udf;
        logic [15:0] dout;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];          // reference contents, head at index 0
    logic [15:0] m_dout = '0;    // reference registered read data
    int          m_depth = 8;
    bit          m_fwft = 1'b0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (fwft=%0d) at %0t: got %0h, expected %0h", name, m_fwft, $time,
                     act, exp);
        end
    endtask

    // Applies one cycle of stimulus, advances the reference model and queues the
    // outputs expected after the coming edge.
    task automatic step(input bit r, input bit f, input bit w, input bit rd,
                        input logic [15:0] d);
        exp_t e;
        bit   is_full;
        bit   is_empty;
        rst_n = r; flush = f; wr_en = w; rd_en = rd; data_in = d;
        e.ack = 1'b0; e.ovf = 1'b0; e.udf = 1'b0;
        if (!r) begin
            mq.delete();
            m_dout = '0;
        end else if (f) begin
            mq.delete();
        end else begin
            is_full  = (mq.size() == m_depth);
            is_empty = (mq.size() == 0);
            if (rd && !is_empty) m_dout = mq.pop_front();
            if (w && !is_full) mq.push_back(d);
            e.ack = w && !is_full;
            e.ovf = w && is_full;
            e.udf = rd && is_empty;
        end
        e.fwft  = m_fwft;
        e.count = mq.size();
        if (m_fwft) e.dout = (mq.size() == 0) ? 16'h0 : mq[0];
        else        e.dout = m_dout;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: every cycle with a pending expectation, compare the active DUT.
    initial begin : monitor
        exp_t e;
        int   af_t, ae_t, cnt, full_a, empty_a, af_a, ae_a, ack_a, ovf_a, udf_a, dout_a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.fwft) begin
                    af_t = int'(af_thresh[2:0]); ae_t = int'(ae_thresh[2:0]);
                    cnt = int'(f_count); full_a = int'(f_full); empty_a = int'(f_empty);
                    af_a = int'(f_af); ae_a = int'(f_ae); ack_a = int'(f_ack);
                    ovf_a = int'(f_ovf); udf_a = int'(f_udf); dout_a = int'(f_dout);
                end else begin
                    af_t = int'(af_thresh); ae_t = int'(ae_thresh);
                    cnt = int'(s_count); full_a = int'(s_full); empty_a = int'(s_empty);
                    af_a = int'(s_af); ae_a = int'(s_ae); ack_a = int'(s_ack);
                    ovf_a = int'(s_ovf); udf_a = int'(s_udf); dout_a = int'(s_dout);
                end
                check("count", cnt, e.count);
                check("full", full_a, int'(e.count == m_depth));
                check("empty", empty_a, int'(e.count == 0));
                check("almostfull", af_a, int'(e.count >= af_t));
                check("almostempty", ae_a, int'(e.count <= ae_t));
                check("wr_ack", ack_a, int'(e.ack));
                check("overflow", ovf_a, int'(e.ovf));
                check("underflow", udf_a, int'(e.udf));
                check("data_out", dout_a, int'(e.dout));
            end
        end
    end

    task automatic random_phase(input int cycles, input int thr_max);
        for (int i = 0; i < cycles; i++) begin
            if (i % 25 == 0) begin
                af_thresh = 4'($urandom_range(thr_max, 0));
                ae_thresh = 4'($urandom_range(thr_max, 0));
            end
            step($urandom_range(99, 0) != 0, $urandom_range(49, 0) == 0,
                 $urandom_range(9, 0) < 6, $urandom_range(9, 0) < 5, 16'($urandom));
        end
    endtask

    initial begin : stimulus
        // ---- standard mode, depth 8 ----
        m_fwft = 1'b0; m_depth = 8;
        af_thresh = 4'd6; ae_thresh = 4'd1;
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 1, 16'h1234);                    // wr/rd ignored during reset
        for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, 16'(i));
        step(1, 0, 1, 0, 16'hDEAD);                    // overflow
        step(1, 0, 1, 1, 16'hBEEF);                    // full: read only, overflow
        step(1, 0, 1, 0, 16'h0009);                    // refill to 8
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 16'h0);
        step(1, 0, 0, 1, 16'h0);                       // underflow, data_out holds
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 1, 1, 16'h00E1);                    // empty: write only, underflow
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 16'(16'h0100 + i));
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 16'(16'h0200 + i));
        step(1, 0, 1, 0, 16'h0300);                    // count 5
        step(1, 1, 1, 0, 16'h0301);                    // flush beats write
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 16'(16'h0400 + i));
        step(0, 0, 1, 1, 16'h0500);                    // reset mid-burst
        step(1, 0, 0, 0, 16'h0);
        random_phase(300, 10);

        // ---- FWFT mode, depth 6 ----
        m_fwft = 1'b1; m_depth = 6;
        af_thresh = 4'd4; ae_thresh = 4'd1;
        step(0, 0, 0, 0, 16'h0);
        step(1, 0, 1, 0, 16'hA5A5);
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 20; i++) step(1, 0, (i % 3) != 2, (i % 2) == 1, 16'(16'hC000 + i));
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 16'(16'hD000 + i));   // fill, overflow
        step(1, 0, 1, 1, 16'hDEAD);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 16'h0);                // drain, underflow
        step(1, 0, 1, 1, 16'hE000);
        random_phase(300, 7);

        step(1, 0, 0, 0, 16'h0);
        repeat (2) @(posedge clk);
        done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (done);
            begin
                #200000;
                errors++;
                $display("FAIL timeout: stimulus did not complete, got running, expected done");
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
